// File: rtl/clk_gate_sched.sv
// clk_gate_sched: per-domain clock-gate enable FSMs with idle hysteresis and round-robin rate-limited wake
module clk_gate_sched #(
  parameter int N_DOM = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic                         CK,
  input  logic                         RST,
  input  logic [N_DOM-1:0]             REQ,
  input  logic                         TEST,
  output logic [N_DOM-1:0]             E_OUT,
  output logic                         SE_OUT,
  output logic [N_DOM-1:0]             RDY,
  output logic [$clog2(N_DOM+1)-1:0]   ACTIVE_CNT
);
  localparam int PW = $clog2(N_DOM);
  localparam int CW = $clog2(N_DOM + 1);
  // The ON->IDLE edge is itself the first low sample, so IDLE only needs IDLE_CYCLES-1 more.
  localparam logic [7:0] ICNT_LD = 8'(IDLE_CYCLES > 1 ? IDLE_CYCLES - 2 : 0);
  localparam logic [3:0] WCNT_LD = 4'(WAKE_LAT - 1);
  typedef enum logic [1:0] {OFF, WAKE, ON, IDLE} st_t;
  st_t              r_st   [N_DOM];
  logic [3:0]       r_wcnt [N_DOM];
  logic [7:0]       r_icnt [N_DOM];
  logic [PW-1:0]    r_ptr, w_win, w_ptr_nxt;
  logic             w_any;
  logic [N_DOM-1:0] w_cand, w_gnt, w_e_nxt, w_rdy_nxt;
  logic [CW-1:0]    w_cnt;
  assign SE_OUT = TEST;
  for (genvar g = 0; g < N_DOM; g++) begin : g_dom
    assign w_cand[g]    = r_st[g] == OFF && REQ[g];
    assign w_e_nxt[g]   = r_st[g] == OFF  ? w_gnt[g] :
                          r_st[g] == IDLE ? REQ[g] || r_icnt[g] != '0 :
                          r_st[g] == ON   ? REQ[g] || IDLE_CYCLES > 1 : 1'b1;
    assign w_rdy_nxt[g] = r_st[g] == WAKE ? r_wcnt[g] == '0 :
                          r_st[g] == OFF  ? 1'b0 : w_e_nxt[g];
  end
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < N_DOM; k++) begin
      if (!w_any && w_cand[PW'((int'(r_ptr) + k) % N_DOM)]) begin
        w_any = 1'b1;
        w_win = PW'((int'(r_ptr) + k) % N_DOM);
      end
    end
    w_gnt     = w_any ? N_DOM'(1) << w_win : '0;
    w_ptr_nxt = w_win == PW'(N_DOM - 1) ? '0 : w_win + 1'b1;
  end
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N_DOM; i++) w_cnt = w_cnt + CW'(w_e_nxt[i]);
  end
  always_ff @(posedge CK) begin
    if (RST) begin
      for (int i = 0; i < N_DOM; i++) begin
        r_st[i]   <= OFF;
        r_wcnt[i] <= '0;
        r_icnt[i] <= '0;
      end
      r_ptr      <= '0;
      E_OUT      <= '0;
      RDY        <= '0;
      ACTIVE_CNT <= '0;
    end else if (!TEST) begin
      for (int i = 0; i < N_DOM; i++) begin
        case (r_st[i])
          OFF: if (w_gnt[i]) begin
            r_st[i]   <= WAKE;
            r_wcnt[i] <= WCNT_LD;
          end
          WAKE: if (r_wcnt[i] == '0) r_st[i] <= ON;
                else r_wcnt[i] <= r_wcnt[i] - 4'd1;
          ON: if (!REQ[i]) begin
            r_st[i]   <= IDLE_CYCLES > 1 ? IDLE : OFF;
            r_icnt[i] <= ICNT_LD;
          end
          IDLE: if (REQ[i]) r_st[i] <= ON;
                else if (r_icnt[i] == '0) r_st[i] <= OFF;
                else r_icnt[i] <= r_icnt[i] - 8'd1;
        endcase
      end
      if (w_any) r_ptr <= w_ptr_nxt;
      E_OUT      <= w_e_nxt;
      RDY        <= w_rdy_nxt;
      ACTIVE_CNT <= w_cnt;
    end
  end
endmodule

// File: tb/tb_clk_gate_sched.sv
// tb_clk_gate_sched: directed literal checks plus randomized run against a counting reference model
module tb_clk_gate_sched;
  localparam int N = 4;
  localparam int IC = 8;
  localparam int WL = 2;
  logic         CK = 1'b0;
  logic         RST = 1'b1;
  logic [N-1:0] REQ = '0;
  logic         TEST = 1'b0;
  logic [N-1:0] E_OUT, RDY;
  logic         SE_OUT;
  logic [2:0]   ACTIVE_CNT;
  int n_tot = 0;
  int n_bad = 0;
  bit chk_en = 0;
  clk_gate_sched #(.N_DOM(N), .IDLE_CYCLES(IC), .WAKE_LAT(WL)) dut (
    .CK(CK), .RST(RST), .REQ(REQ), .TEST(TEST),
    .E_OUT(E_OUT), .SE_OUT(SE_OUT), .RDY(RDY), .ACTIVE_CNT(ACTIVE_CNT)
  );
  always #5 CK = ~CK;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge CK);
  endtask
  // reference: a powered domain becomes ready WL edges after its grant, and powers off
  // once it has seen IC consecutive low requests after becoming ready
  bit m_e [N];
  bit m_r [N];
  int m_age [N];
  int m_zr [N];
  int m_ptr;
  int w;
  int idx;
  always @(posedge CK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        m_e[i] = 0; m_r[i] = 0; m_age[i] = 0; m_zr[i] = 0;
      end
      m_ptr = 0;
      chk_en = 1;
    end else if (!TEST) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && !m_e[idx] && REQ[idx]) w = idx;
      end
      for (int i = 0; i < N; i++) begin
        if (!m_e[i]) begin
          if (i == w) begin m_e[i] = 1; m_age[i] = 0; end
        end else if (!m_r[i]) begin
          m_age[i]++;
          if (m_age[i] == WL) begin m_r[i] = 1; m_zr[i] = 0; end
        end else begin
          m_zr[i] = REQ[i] ? 0 : m_zr[i] + 1;
          if (m_zr[i] == IC) begin m_e[i] = 0; m_r[i] = 0; end
        end
      end
      if (w >= 0) m_ptr = (w + 1) % N;
    end
  end
  always begin
    logic [N-1:0] me, mr;
    int mc;
    @(negedge CK);
    #1;
    if (chk_en) begin
      mc = 0;
      for (int i = 0; i < N; i++) begin
        me[i] = m_e[i];
        mr[i] = m_r[i];
        mc += int'(m_e[i]);
      end
      chk("model_e", E_OUT, me);
      chk("model_rdy", RDY, mr);
      chk("model_cnt", ACTIVE_CNT, mc);
      chk("model_se", SE_OUT, TEST);
    end
  end
  task automatic do_reset();
    RST = 1'b1;
    cyc(1);
    RST = 1'b0;
  endtask
  initial begin
    cyc(2);
    RST = 1'b0;
    chk("rst_e", E_OUT, 4'b0000);
    chk("rst_rdy", RDY, 4'b0000);
    chk("rst_cnt", ACTIVE_CNT, 0);
    REQ = 4'b0010;
    cyc(1);
    chk("wake_e", E_OUT, 4'b0010);
    chk("wake_rdy0", RDY, 4'b0000);
    chk("wake_cnt", ACTIVE_CNT, 1);
    cyc(1);
    chk("wake_rdy1", RDY, 4'b0000);
    cyc(1);
    chk("wake_rdy2", RDY, 4'b0010);
    REQ = 4'b0000;
    cyc(7);
    chk("idle_hold", E_OUT, 4'b0010);
    cyc(1);
    chk("idle_off_e", E_OUT, 4'b0000);
    chk("idle_off_rdy", RDY, 4'b0000);
    chk("idle_off_cnt", ACTIVE_CNT, 0);
    REQ = 4'b0010;
    cyc(3);
    REQ = 4'b0000;
    cyc(3);
    REQ = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("cancel_e", E_OUT, 4'b0010);
      chk("cancel_rdy", RDY, 4'b0010);
    end
    do_reset();
    REQ = 4'b1111;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk("cont1_e", E_OUT, 32'((1 << k) - 1));
      chk("cont1_cnt", ACTIVE_CNT, k);
    end
    REQ = 4'b0000;
    cyc(20);
    chk("cont_alloff", E_OUT, 4'b0000);
    REQ = 4'b0010;
    cyc(1);
    REQ = 4'b0000;
    cyc(14);
    chk("cont_ptr2_off", E_OUT, 4'b0000);
    REQ = 4'b1111;
    cyc(1); chk("cont2_e1", E_OUT, 4'b0100);
    cyc(1); chk("cont2_e2", E_OUT, 4'b1100);
    cyc(1); chk("cont2_e3", E_OUT, 4'b1101);
    cyc(1); chk("cont2_e4", E_OUT, 4'b1111);
    chk("cont2_cnt", ACTIVE_CNT, 4);
    REQ = 4'b0000;
    do_reset();
    REQ = 4'b0100;
    cyc(1);
    chk("frz_e", E_OUT, 4'b0100);
    TEST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("frz_se", SE_OUT, 1);
      chk("frz_hold_e", E_OUT, 4'b0100);
      chk("frz_hold_rdy", RDY, 4'b0000);
    end
    TEST = 1'b0;
    cyc(1);
    chk("frz_se0", SE_OUT, 0);
    chk("frz_rdy_a", RDY, 4'b0000);
    cyc(1);
    chk("frz_rdy_b", RDY, 4'b0100);
    do_reset();
    REQ = 4'b1001;
    cyc(1); chk("mid_e1", E_OUT, 4'b0001);
    cyc(1); chk("mid_e2", E_OUT, 4'b1001);
    cyc(3); chk("mid_rdy", RDY, 4'b1001);
    RST = 1'b1;
    cyc(1);
    chk("mid_rst_e", E_OUT, 4'b0000);
    chk("mid_rst_rdy", RDY, 4'b0000);
    chk("mid_rst_cnt", ACTIVE_CNT, 0);
    RST = 1'b0;
    REQ = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) REQ[i] = ~REQ[i];
      if (TEST) TEST = $urandom_range(0, 3) != 0;
      else TEST = $urandom_range(0, 39) == 0;
      RST = $urandom_range(0, 299) == 0;
      cyc(1);
    end
    RST = 1'b0;
    TEST = 1'b0;
    cyc(2);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
